// File: rtl/seq_divider_32bit_if.sv
// seq_divider_32bit_if
//   Start/busy/done handshake and operand/result bus between the control unit
//   (master) and the sequential divider (slave).
//   start, is_signed, dividend, divisor : request, driven by the control unit
//   busy, done                           : handshake status from the divider
//   quotient, remainder, div_by_zero     : results (LO, HI, flag)
interface seq_divider_32bit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider_32bit.sv
// seq_divider_32bit
//   Multi-cycle restoring divider for DIV / DIVU. One quotient bit per clock,
//   34-cycle stall for a normal op, 2 cycles for a zero divisor.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : slave side of seq_divider_32bit_if (start/busy/done, operands,
//           quotient = LO, remainder = HI, div_by_zero flag)
module seq_divider_32bit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                clk,
   input  logic                reset,
   seq_divider_32bit_if.slave  bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DIVIDE = 2'd1;
   localparam logic [1:0] FIX    = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;       // partial remainder (magnitude)
   logic [WIDTH-1:0] quo;       // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvsr;      // divisor magnitude
   logic             neg_q;
   logic             neg_r;
   logic             dbz_op;    // current op has a zero divisor

   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic             dbz_r;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // abs() of the most negative value wraps to itself, which is the correct
   // unsigned magnitude 2^(WIDTH-1); no special case is needed.
   assign a_mag = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
   assign b_mag = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

   // rem < dvsr always holds, so the WIDTH+1-bit difference has its top bit
   // set exactly when the trial subtraction would go negative.
   assign shifted = {rem, quo[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvsr};

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         rem         <= '0;
         quo         <= '0;
         dvsr        <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dbz_op      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
         dbz_r       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_r <= 1'b1;
                  if (bus.divisor == '0) begin
                     // Zero divisor still passes through FIX so that done
                     // appears one edge after acceptance; quo keeps the raw
                     // dividend for the remainder output.
                     dbz_op <= 1'b1;
                     quo    <= bus.dividend;
                     state  <= FIX;
                  end else begin
                     dbz_op <= 1'b0;
                     quo    <= a_mag;
                     dvsr   <= b_mag;
                     neg_q  <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                     neg_r  <= bus.is_signed & bus.dividend[WIDTH-1];
                     rem    <= '0;
                     cnt    <= '0;
                     dbz_r  <= 1'b0;
                     state  <= DIVIDE;
                  end
               end
            end

            DIVIDE: begin
               if (!trial[WIDTH]) begin
                  rem <= trial[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST) state <= FIX;
            end

            FIX: begin
               if (dbz_op) begin
                  quotient_r  <= '1;
                  remainder_r <= quo;
                  dbz_r       <= 1'b1;
               end else begin
                  quotient_r  <= neg_q ? -quo : quo;
                  remainder_r <= neg_r ? -rem : rem;
               end
               done_r <= 1'b1;
               state  <= DONE;
            end

            DONE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider_32bit.sv
// tb_seq_divider_32bit
//   Self-checking bench for seq_divider_32bit: directed corners plus random
//   operands checked against a plain-arithmetic reference model.
module tb_seq_divider_32bit;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   fails  = 0;

   seq_divider_32bit_if #(.WIDTH(32)) bus ();

   seq_divider_32bit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: truncating division; remainder carries the dividend's sign.
   function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output logic z);
      longint sa, sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; z = 1'b1;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
         z  = 1'b0;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endfunction

   // Issues one op and waits (bounded) for done; lat = -1 if done never came.
   task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_acc,
                        output logic [31:0] q, output logic [31:0] r, output logic z,
                        output logic busy_end, output logic done_end);
      bus.is_signed = s; bus.dividend = a; bus.divisor = b; bus.start = 1'b1;
      step();
      busy_acc = bus.busy;
      bus.start = 1'b0;
      bus.dividend = $urandom; bus.divisor = $urandom;
      lat = -1;
      for (int t = 1; t <= 40; t++) begin
         step();
         if (bus.done) begin lat = t; break; end
      end
      q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
      step();
      busy_end = bus.busy; done_end = bus.done;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
      checks++; if (bus.quotient !== 32'd0) begin fails++; $display("FAIL reset_quotient got %h want 0", bus.quotient); end
      checks++; if (bus.remainder !== 32'd0) begin fails++; $display("FAIL reset_remainder got %h want 0", bus.remainder); end
      checks++; if (bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
      reset = 1'b0;
      step();
   endtask

   task automatic run_table(input string name, input bit s, input logic [31:0] a, input logic [31:0] b);
      int lat; logic ba, be, de, z, ez; logic [31:0] q, r, eq, er;
      do_op(s, a, b, lat, ba, q, r, z, be, de);
      model(s, a, b, eq, er, ez);
      checks++; if (ba !== 1'b1) begin fails++; $display("FAIL %s busy_after_start got %b want 1", name, ba); end
      checks++; if (lat != ((b == 0) ? 1 : 33)) begin fails++; $display("FAIL %s done_latency got %0d want %0d", name, lat, (b == 0) ? 1 : 33); end
      checks++; if (q !== eq) begin fails++; $display("FAIL %s quotient %h/%h got %h want %h", name, a, b, q, eq); end
      checks++; if (r !== er) begin fails++; $display("FAIL %s remainder %h/%h got %h want %h", name, a, b, r, er); end
      checks++; if (z !== ez) begin fails++; $display("FAIL %s dbz got %b want %b", name, z, ez); end
      checks++; if (be !== 1'b0 || de !== 1'b0) begin fails++; $display("FAIL %s end_state busy=%b done=%b want 0 0", name, be, de); end
   endtask

   task automatic test_unsigned();
      logic [31:0] a, b;
      run_table("divu_100_7", 1'b0, 32'd100, 32'd7);
      run_table("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
      run_table("divu_5_9",   1'b0, 32'd5, 32'd9);
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         run_table("divu_rand", 1'b0, a, b);
      end
   endtask

   task automatic test_signed();
      logic [31:0] a, b;
      run_table("div_m100_7",    1'b1, 32'hFFFF_FF9C, 32'd7);
      run_table("div_100_m7",    1'b1, 32'd100, 32'hFFFF_FFF9);
      run_table("div_min_m1",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = $urandom;
         b = $urandom_range(0, 1) ? (b >>> $urandom_range(0, 31)) : $signed(b) >>> $urandom_range(0, 31);
         run_table("div_rand", 1'b1, a, b);
      end
   endtask

   task automatic test_div_zero();
      run_table("div_zero", 1'b1, 32'd12345, 32'd0);
      checks++; if (bus.div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_held got %b want 1", bus.div_by_zero); end
      run_table("dbz_clear", 1'b0, 32'd81, 32'd9);
   endtask

   // Start pulses during iteration 5 and during the DONE->IDLE edge are ignored.
   task automatic test_ignore_start();
      int done_cnt = 0, done_t = -1;
      logic [31:0] q = 0, r = 0, eq, er; logic ez;
      logic b35 = 1'b1, b36 = 1'b1;
      model(1'b0, 32'd1000000, 32'd37, eq, er, ez);
      bus.is_signed = 1'b0; bus.dividend = 32'd1000000; bus.divisor = 32'd37; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int t = 1; t <= 36; t++) begin
         bus.start = (t == 5 || t == 34);
         bus.dividend = $urandom; bus.divisor = $urandom; bus.is_signed = $urandom_range(0, 1);
         step();
         if (bus.done) begin done_cnt++; done_t = t; q = bus.quotient; r = bus.remainder; end
         if (t == 35) b35 = bus.busy;
         if (t == 36) b36 = bus.busy;
      end
      bus.start = 1'b0;
      checks++; if (done_cnt != 1 || done_t != 33) begin fails++; $display("FAIL ign_done count=%0d at=%0d want 1 at 33", done_cnt, done_t); end
      checks++; if (q !== eq) begin fails++; $display("FAIL ign_quotient got %h want %h", q, eq); end
      checks++; if (r !== er) begin fails++; $display("FAIL ign_remainder got %h want %h", r, er); end
      checks++; if (b35 !== 1'b0 || b36 !== 1'b0) begin fails++; $display("FAIL ign_late_start busy=%b%b want 00", b35, b36); end
   endtask

   // Held start: op A done at t=33, one idle cycle at t=34, op B accepted at 35.
   task automatic test_back_to_back();
      logic [31:0] qa, ra, qb, rb; logic za, zb;
      logic [31:0] gqa = 0, gra = 0, gqb = 0, grb = 0;
      logic [69:0] busy_tr = '0, done_tr = '0;
      logic [31:0] a1, b1, a2, b2;
      a1 = $urandom; b1 = ($urandom >> 20) | 32'd1;
      a2 = $urandom; b2 = ($urandom >> 24) | 32'd1;
      model(1'b1, a1, b1, qa, ra, za);
      model(1'b1, a2, b2, qb, rb, zb);
      bus.is_signed = 1'b1; bus.dividend = a1; bus.divisor = b1; bus.start = 1'b1;
      step();
      bus.dividend = a2; bus.divisor = b2;
      for (int t = 1; t <= 69; t++) begin
         if (t == 69) bus.start = 1'b0;
         step();
         busy_tr[t] = bus.busy; done_tr[t] = bus.done;
         if (t == 33) begin gqa = bus.quotient; gra = bus.remainder; end
         if (t == 68) begin gqb = bus.quotient; grb = bus.remainder; end
      end
      bus.start = 1'b0;
      checks++; if (done_tr[33] !== 1'b1 || done_tr[68] !== 1'b1) begin fails++; $display("FAIL b2b_done t33=%b t68=%b want 1 1", done_tr[33], done_tr[68]); end
      checks++; if (busy_tr[34] !== 1'b0 || busy_tr[35] !== 1'b1 || busy_tr[33] !== 1'b1) begin fails++; $display("FAIL b2b_idle_gap busy t33..35=%b%b%b want 101", busy_tr[33], busy_tr[34], busy_tr[35]); end
      checks++; if (gqa !== qa || gra !== ra) begin fails++; $display("FAIL b2b_first got %h r %h want %h r %h", gqa, gra, qa, ra); end
      checks++; if (gqb !== qb || grb !== rb) begin fails++; $display("FAIL b2b_second got %h r %h want %h r %h", gqb, grb, qb, rb); end
      step(); step();
   endtask

   task automatic test_reset_mid();
      int done_cnt = 0;
      bus.is_signed = 1'b0; bus.dividend = 32'd999999; bus.divisor = 32'd13; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int t = 1; t <= 15; t++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL rst_mid_hs busy=%b done=%b want 0 0", bus.busy, bus.done); end
      checks++; if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL rst_mid_results q=%h r=%h z=%b want 0", bus.quotient, bus.remainder, bus.div_by_zero); end
      for (int t = 0; t < 40; t++) begin
         step();
         if (bus.done) done_cnt++;
      end
      checks++; if (done_cnt != 0) begin fails++; $display("FAIL rst_mid_no_done got %0d pulses want 0", done_cnt); end
      run_table("rst_then_81_9", 1'b0, 32'd81, 32'd9);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
